// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 2-read/1-write integer register file with a per-register
// busy scoreboard for decode-stage hazard detection.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
// Without the macro, reads return the stored value and busy flags reflect the
// stored busy bits only.
module regfile_scoreboard #(
    parameter int XLEN     = 64,
    parameter int DEPTH    = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            regWrite,
    input  logic [AW-1:0]   writeRegister,
    input  logic [XLEN-1:0] writeData,
    input  logic [AW-1:0]   readRegister1,
    input  logic [AW-1:0]   readRegister2,
    output logic [XLEN-1:0] readData1,
    output logic [XLEN-1:0] readData2,
    input  logic            issueValid,
    input  logic [AW-1:0]   issueRegister,
    output logic            busy1,
    output logic            busy2,
    output logic [AW:0]     busyCount
);

    localparam logic [AW:0] CountOne = (AW+1)'(1);

    logic [XLEN-1:0]  regs [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busyNext;
    logic             wrEn;
    logic             setEn;
    logic             incCnt;
    logic             decCnt;

    // Register 0 is hard-wired to zero when ZERO_REG is set.
    function automatic logic isZeroReg(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    assign wrEn  = regWrite && !isZeroReg(writeRegister);
    assign setEn = issueValid && !isZeroReg(issueRegister);

    // The count moves only when a busy bit actually flips; a set on the
    // register being cleared in the same cycle keeps it busy.
    assign incCnt = setEn && !busy[issueRegister];
    assign decCnt = regWrite && busy[writeRegister]
                    && !(setEn && (issueRegister == writeRegister));

    // Next busy vector: write-back clears first, then a new issue sets (set wins).
    always_comb begin
        busyNext = busy;
        if (regWrite) begin
            busyNext[writeRegister] = 1'b0;
        end
        if (setEn) begin
            busyNext[issueRegister] = 1'b1;
        end
    end

    // Register array: cleared by reset, written by write-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wrEn) begin
            regs[writeRegister] <= writeData;
        end
    end

    // Busy bits and their population count, updated together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy      <= '0;
            busyCount <= '0;
        end else begin
            busy <= busyNext;
            if (incCnt && !decCnt) begin
                busyCount <= busyCount + CountOne;
            end else if (decCnt && !incCnt) begin
                busyCount <= busyCount - CountOne;
            end
        end
    end

    // Read port 1: stored value, zero-masked, optionally forwarded from write-back.
    always_comb begin
        readData1 = regs[readRegister1];
        busy1     = busy[readRegister1];
        if (rst || isZeroReg(readRegister1)) begin
            readData1 = '0;
            busy1     = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (regWrite && (writeRegister == readRegister1)) begin
            readData1 = writeData;
            if (!(issueValid && (issueRegister == readRegister1))) begin
                busy1 = 1'b0;
            end
        end
`endif
    end

    // Read port 2: same behaviour as port 1.
    always_comb begin
        readData2 = regs[readRegister2];
        busy2     = busy[readRegister2];
        if (rst || isZeroReg(readRegister2)) begin
            readData2 = '0;
            busy2     = 1'b0;
        end
`ifdef REGFILE_BYPASS_EN
        else if (regWrite && (writeRegister == readRegister2)) begin
            readData2 = writeData;
            if (!(issueValid && (issueRegister == readRegister2))) begin
                busy2 = 1'b0;
            end
        end
`endif
    end

endmodule
